// File: rtl/mem_port_sched.sv
// mem_port_sched: schedules one read-burst port, one write-burst port and a
// backdoor single-word writer onto a single-ported (one op per cycle) RAM.
//
// Handshake semantics: rd_req/wr_req are held until the matching one-cycle
// gnt pulse. A read beat transfers on a rising edge where rd_valid && rd_ready;
// rd_data/rd_last stay stable while rd_valid && !rd_ready. A write beat
// transfers on a rising edge where wr_valid && wr_ready. bd_en has no
// handshake and always takes the RAM write port in its cycle.
module mem_port_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_AW     = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [7:0]            rd_len,
  output logic                  rd_gnt,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  input  logic                  rd_ready,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [7:0]            wr_len,
  output logic                  wr_gnt,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  input  logic                  wr_last,
  output logic                  wr_ready,
  input  logic                  bd_en,
  input  logic [ADDR_WIDTH-1:0] bd_addr,
  input  logic [DATA_WIDTH-1:0] bd_data,
  output logic                  ram_we,
  output logic [RAM_AW-1:0]     ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_re,
  output logic [RAM_AW-1:0]     ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  err_wlast,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  localparam logic [RAM_AW-1:0] IDX_ONE = {{(RAM_AW-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic                  last_wr_q, last_wr_d;     // last grant was a write
  logic [RAM_AW-1:0]     idx_q, idx_d;             // next word index of burst
  logic [8:0]            beats_q, beats_d;         // read: beats to issue; write: beats left
  logic                  inflight_q, inflight_d;   // RAM read returns this cycle
  logic                  inflight_last_q, inflight_last_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic                  fifo_last_q [2];
  logic                  fifo_wp_q, fifo_rp_q;
  logic [1:0]            fifo_cnt_q;

  logic                  gnt_rd, gnt_wr, issue, wr_fire, pop, push;
  logic [2:0]            occ;
  logic [RAM_AW-1:0]     bd_idx;

  // Address bits outside the RAM word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_addr[ADDR_WIDTH-1:RAM_AW+2], rd_addr[1:0],
                              wr_addr[ADDR_WIDTH-1:RAM_AW+2], wr_addr[1:0],
                              bd_addr[ADDR_WIDTH-1:RAM_AW+2], bd_addr[1:0]};

  assign bd_idx = bd_addr[RAM_AW+1:2];
  assign pop    = (fifo_cnt_q != 2'd0) && rd_ready;
  assign push   = inflight_q;
  // Entries held or owed to the FIFO after this cycle's pop, before any new issue.
  assign occ    = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

  // Next-state: arbitration, burst address/beat tracking, wr_last checking.
  always_comb begin
    state_d         = state_q;
    last_wr_d       = last_wr_q;
    idx_d           = idx_q;
    beats_d         = beats_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    err_d           = err_q;
    gnt_rd          = 1'b0;
    gnt_wr          = 1'b0;
    issue           = 1'b0;
    wr_fire         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rd_req && (!wr_req || last_wr_q)) begin
          gnt_rd    = 1'b1;
          state_d   = S_RD;
          last_wr_d = 1'b0;
          idx_d     = rd_addr[RAM_AW+1:2];
          beats_d   = {1'b0, rd_len} + 9'd1;
        end else if (wr_req) begin
          gnt_wr    = 1'b1;
          state_d   = S_WR;
          last_wr_d = 1'b1;
          idx_d     = wr_addr[RAM_AW+1:2];
          beats_d   = {1'b0, wr_len} + 9'd1;
        end
      end
      S_RD: begin
        if ((beats_q != 9'd0) && !bd_en && (occ < 3'd2)) begin
          issue           = 1'b1;
          idx_d           = idx_q + IDX_ONE;
          beats_d         = beats_q - 9'd1;
          inflight_d      = 1'b1;
          inflight_last_d = (beats_q == 9'd1);
        end
        if (pop && fifo_last_q[fifo_rp_q]) state_d = S_IDLE;
      end
      S_WR: begin
        wr_fire = wr_valid && !bd_en;
        if (wr_fire) begin
          idx_d   = idx_q + IDX_ONE;
          beats_d = beats_q - 9'd1;
          if (beats_q == 9'd1) begin
            if (!wr_last) err_d = 1'b1;
            state_d = S_IDLE;
          end else if (wr_last) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q         <= S_IDLE;
      last_wr_q       <= 1'b1;
      idx_q           <= '0;
      beats_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_wr_q       <= last_wr_d;
      idx_q           <= idx_d;
      beats_q         <= beats_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      err_q           <= err_d;
    end
  end

  // Two-entry read-data FIFO fed by the RAM one cycle after each issue.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q[0] <= 1'b0;
      fifo_last_q[1] <= 1'b0;
      fifo_wp_q      <= 1'b0;
      fifo_rp_q      <= 1'b0;
      fifo_cnt_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_data_q[fifo_wp_q] <= ram_rdata;
        fifo_last_q[fifo_wp_q] <= inflight_last_q;
        fifo_wp_q              <= ~fifo_wp_q;
      end
      if (pop) fifo_rp_q <= ~fifo_rp_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Outputs; everything is forced quiet while reset is asserted.
  always_comb begin
    rd_gnt    = gnt_rd & ~ARESET;
    wr_gnt    = gnt_wr & ~ARESET;
    rd_valid  = (fifo_cnt_q != 2'd0) & ~ARESET;
    rd_data   = rd_valid ? fifo_data_q[fifo_rp_q] : '0;
    rd_last   = rd_valid & fifo_last_q[fifo_rp_q];
    wr_ready  = (state_q == S_WR) & ~bd_en & ~ARESET;
    ram_we    = (bd_en | wr_fire) & ~ARESET;
    ram_waddr = '0;
    ram_wdata = '0;
    if (ram_we) begin
      ram_waddr = bd_en ? bd_idx : idx_q;
      ram_wdata = bd_en ? bd_data : wr_data;
    end
    ram_re    = issue & ~ARESET;
    ram_raddr = ram_re ? idx_q : '0;
    busy      = (state_q != S_IDLE) & ~ARESET;
    err_wlast = err_q & ~ARESET;
    dbg_state = ARESET ? S_IDLE : state_q;
  end

endmodule

// File: tb/tb_mem_port_sched.sv
// tb_mem_port_sched: randomized and directed bench for mem_port_sched with a
// word-array reference memory and an expected queue of read beats.
module tb_mem_port_sched;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int RAW = 6;
  localparam int NW  = 1 << RAW;

  // ---------------- clock / reset / signals ----------------
  logic ACLK = 1'b0;
  logic ARESET;
  logic rd_req, rd_gnt, rd_valid, rd_last, rd_ready;
  logic [AW-1:0] rd_addr, wr_addr, bd_addr;
  logic [7:0] rd_len, wr_len;
  logic [DW-1:0] rd_data, wr_data, bd_data, ram_wdata, ram_rdata;
  logic wr_req, wr_gnt, wr_valid, wr_last, wr_ready, bd_en;
  logic ram_we, ram_re, busy, err_wlast;
  logic [RAW-1:0] ram_waddr, ram_raddr;
  logic [1:0] dbg_state;

  always #5 ACLK = ~ACLK;

  mem_port_sched #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_AW(RAW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_gnt(rd_gnt),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_gnt(wr_gnt),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_last(wr_last), .wr_ready(wr_ready),
    .bd_en(bd_en), .bd_addr(bd_addr), .bd_data(bd_data),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .busy(busy), .err_wlast(err_wlast), .dbg_state(dbg_state)
  );

  // RAM attached to the DUT: write on the edge, read data one cycle later.
  logic [DW-1:0] ram [NW] = '{default: '0};
  always @(posedge ACLK) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= ram[ram_raddr];
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] gold [NW] = '{default: '0};   // what memory must hold
  bit            last_wr_m = 1'b1;              // last grant was a write
  logic [DW:0]   exp_q [$];                     // {last, data} per read beat

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] ctrl_vec();
    return {rd_gnt, wr_gnt, rd_valid, rd_last, wr_ready, ram_we, ram_re, busy, err_wlast};
  endfunction

  // Scoreboard: every accepted read beat against the expected queue, and RAM exclusivity.
  logic [DW:0] mon_e;
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (ram_we || ram_re) check_eq("ram_excl", ram_we & ram_re, 0);
      if (rd_valid && rd_ready) begin
        check_eq("rd_exp_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check_eq("rd_data", rd_data, mon_e[DW-1:0]);
          check_eq("rd_last", rd_last, mon_e[DW]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Tasks start and end just after a rising edge (drive phase).
  task automatic tick_sample(); @(negedge ACLK); #1; endtask
  task automatic tick_drive();  @(posedge ACLK); #1; endtask

  function automatic logic [AW-1:0] mk_addr(input int idx, input bit junk);
    logic [AW-1:0] a;
    a = junk ? AW'($urandom) : '0;
    a[RAW+1:2] = idx[RAW-1:0];
    return a;
  endfunction

  task automatic do_reset(input int n);
    ARESET = 1'b1;
    rd_req = 0; wr_req = 0; wr_valid = 0; wr_last = 0; rd_ready = 0; bd_en = 0;
    repeat (n) begin
      tick_sample();
      check_eq("rst_ctrl", ctrl_vec(), 0);
      check_eq("rst_data", {rd_data, ram_wdata}, 0);
      check_eq("rst_addr", {ram_waddr, ram_raddr}, 0);
      tick_drive();
    end
    ARESET = 1'b0;
    exp_q.delete();
    last_wr_m = 1'b1;
  endtask

  task automatic bd_write(input int idx, input logic [DW-1:0] d);
    bd_en = 1; bd_addr = mk_addr(idx, 1); bd_data = d;
    tick_sample();
    check_eq("bd_port", {ram_we, ram_re, ram_waddr, ram_wdata}, {2'b10, idx[RAW-1:0], d});
    gold[idx % NW] = d;
    tick_drive();
    bd_en = 0;
  endtask

  task automatic request(input bit want_rd, input bit want_wr,
                         input logic [AW-1:0] ra, input int rl,
                         input logic [AW-1:0] wa, input int wl,
                         output bit got_rd, output bit got_wr);
    bit exp_rd, exp_wr, got;
    exp_rd = want_rd && (!want_wr || last_wr_m);
    exp_wr = want_wr && !exp_rd;
    rd_req = want_rd; rd_addr = ra; rd_len = 8'(rl);
    wr_req = want_wr; wr_addr = wa; wr_len = 8'(wl);
    got = 0; got_rd = 0; got_wr = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick_sample();
      if (rd_gnt || wr_gnt) begin
        got = 1; got_rd = rd_gnt; got_wr = wr_gnt;
      end
      tick_drive();
    end
    rd_req = 0; wr_req = 0;
    check_eq("gnt_seen", got, 1);
    check_eq("gnt_rd", got_rd, exp_rd);
    check_eq("gnt_wr", got_wr, exp_wr);
    if (got_rd) last_wr_m = 1'b0;
    if (got_wr) last_wr_m = 1'b1;
  endtask

  // mode: 0 ready always, 1 ready toggling, 2 ready random
  task automatic read_data(input int idx, input int len, input int mode);
    int got, first, cyc;
    for (int i = 0; i <= len; i++) exp_q.push_back({i == len, gold[(idx + i) % NW]});
    got = 0; first = -1; cyc = 0;
    while (got < len + 1 && cyc < 40 * (len + 1) + 20) begin
      rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc[0] == 1'b0) : 1'($urandom_range(0, 1));
      tick_sample();
      if (rd_valid && rd_ready) begin
        if (first < 0) first = cyc;
        got++;
      end
      cyc++;
      tick_drive();
    end
    rd_ready = 0;
    check_eq("rd_beats", got, len + 1);
    if (mode == 0) begin
      check_eq("rd_first_lat", first, 2);
      check_eq("rd_rate", cyc - 1 - first, len);
    end
    tick_sample();
    check_eq("rd_to_idle", busy, 0);
    tick_drive();
  endtask

  // bd_mode: 0 none, 1 every other cycle, 2 random
  task automatic write_data(input int idx, input int len, input int bd_mode,
                            input bit bad_last, input bit seq_data, input int bd_base);
    int beat, cyc, nbd, bidx;
    beat = 0; cyc = 0; nbd = 0; bidx = 0;
    while (beat <= len && cyc < 40 * (len + 1) + 20) begin
      bd_en = (bd_mode == 1) ? (cyc[0] == 1'b0) :
              (bd_mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (bd_en) begin
        bidx = (bd_mode == 1) ? (bd_base + nbd) % NW : int'($urandom_range(0, NW - 1));
        bd_addr = mk_addr(bidx, 1);
        bd_data = $urandom;
      end
      wr_valid = (bd_mode == 1 || seq_data) ? 1'b1 : ($urandom_range(0, 3) != 0);
      wr_data  = seq_data ? DW'(beat + 1) : DW'($urandom);
      wr_last  = (beat == len) ^ bad_last;
      tick_sample();
      check_eq("wr_ready", wr_ready, !bd_en);
      if (bd_en) begin
        check_eq("bd_in_wr", {ram_we, ram_waddr, ram_wdata}, {1'b1, bidx[RAW-1:0], bd_data});
        gold[bidx] = bd_data;
        nbd++;
      end
      if (wr_valid && wr_ready) begin
        check_eq("wr_port", {ram_we, ram_waddr, ram_wdata},
                 {1'b1, 6'((idx + beat) % NW), wr_data});
        gold[(idx + beat) % NW] = wr_data;
        beat++;
      end
      cyc++;
      tick_drive();
    end
    wr_valid = 0; wr_last = 0; bd_en = 0;
    check_eq("wr_beats", beat, len + 1);
    tick_sample();
    check_eq("wr_to_idle", busy, 0);
    tick_drive();
  endtask

  task automatic run_granted(input bit gr, input bit gw, input int ridx, input int rl,
                             input int widx, input int wl, input int rmode, input int bdm);
    if (gr) read_data(ridx, rl, rmode);
    if (gw) write_data(widx, wl, bdm, 1'b0, 1'b0, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit gr, gw;
    int op, ri, rl, wi, wl;
    rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0; rd_len = '0; wr_len = '0;
    wr_data = '0; wr_valid = 0; wr_last = 0; rd_ready = 0;
    bd_en = 0; bd_addr = '0; bd_data = '0; ARESET = 1;
    tick_drive();
    do_reset(3);
    tick_sample();
    check_eq("post_rst_ctrl", ctrl_vec(), 0);
    tick_drive();

    // Backdoor preload then single-beat read with exact latency.
    bd_write(16, 32'hDEADBEEF);
    request(1, 0, 32'h40, 0, '0, 0, gr, gw);
    exp_q.push_back({1'b1, 32'hDEADBEEF});
    rd_ready = 1;
    tick_sample();
    check_eq("t1_ram_re", {rd_gnt, ram_re, ram_raddr, rd_valid}, {2'b01, 6'h10, 1'b0});
    tick_drive();
    tick_sample();
    check_eq("t2_quiet", {ram_re, rd_valid}, 2'b00);
    tick_drive();
    tick_sample();
    check_eq("t3_beat", {rd_valid, rd_last, rd_data}, {2'b11, 32'hDEADBEEF});
    tick_drive();
    tick_sample();
    check_eq("t4_idle", {busy, rd_valid}, 2'b00);
    tick_drive();
    rd_ready = 0;

    // Round-robin when both request together.
    for (int k = 0; k < 4; k++) begin
      request(1, 1, mk_addr(4 * k, 1), 1, mk_addr(32 + 4 * k, 1), 2, gr, gw);
      run_granted(gr, gw, 4 * k, 1, 32 + 4 * k, 2, 0, 0);
    end

    // Sequential data write then read back with a toggling consumer.
    request(0, 1, '0, 0, 32'h0, 3, gr, gw);
    write_data(0, 3, 0, 1'b0, 1'b1, 0);
    request(1, 0, 32'h0, 3, '0, 0, gr, gw);
    read_data(0, 3, 1);

    // Backdoor every other cycle during an 8-beat write.
    request(0, 1, '0, 0, mk_addr(8, 1), 7, gr, gw);
    write_data(8, 7, 1, 1'b0, 1'b0, 40);
    request(1, 0, mk_addr(8, 0), 7, '0, 0, gr, gw);
    read_data(8, 7, 0);
    request(1, 0, mk_addr(40, 0), 7, '0, 0, gr, gw);
    read_data(40, 7, 2);

    // Index wrap at the top of the RAM.
    request(0, 1, '0, 0, mk_addr(62, 1), 3, gr, gw);
    write_data(62, 3, 0, 1'b0, 1'b0, 0);
    request(1, 0, mk_addr(61, 1), 4, '0, 0, gr, gw);
    read_data(61, 4, 0);
    check_eq("err_clean", err_wlast, 0);

    // Randomized mix of reads, writes and simultaneous requests.
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 2);
      ri = $urandom_range(0, NW - 1); rl = ($urandom_range(0, 4) == 0) ? $urandom_range(8, 20) : $urandom_range(0, 7);
      wi = $urandom_range(0, NW - 1); wl = ($urandom_range(0, 4) == 0) ? $urandom_range(8, 20) : $urandom_range(0, 7);
      request(op != 1, op != 0, mk_addr(ri, 1), rl, mk_addr(wi, 1), wl, gr, gw);
      run_granted(gr, gw, ri, rl, wi, wl, $urandom_range(0, 2), 2);
    end
    check_eq("err_clean_rand", err_wlast, 0);

    // Misplaced wr_last sets a sticky error.
    request(0, 1, '0, 0, mk_addr(20, 0), 1, gr, gw);
    write_data(20, 1, 0, 1'b1, 1'b0, 0);
    repeat (3) begin
      tick_sample();
      check_eq("err_sticky", err_wlast, 1);
      tick_drive();
    end

    // Reset in the middle of a stalled 4-beat read, with bd_en asserted.
    request(1, 0, mk_addr(0, 0), 3, '0, 0, gr, gw);
    rd_ready = 0;
    repeat (4) begin
      tick_sample();
      tick_drive();
    end
    ARESET = 1; bd_en = 1; bd_addr = mk_addr(5, 0); bd_data = 32'h5A5A5A5A;
    tick_sample();
    check_eq("rst_mid_ctrl", ctrl_vec(), 0);
    tick_drive();
    ARESET = 0; bd_en = 0;
    exp_q.delete();
    last_wr_m = 1'b1;
    tick_sample();
    check_eq("after_rst", {rd_valid, busy, err_wlast}, 3'b000);
    tick_drive();

    // Recovery: read wins the first tie again; memory untouched by the reset-cycle bd.
    request(1, 1, mk_addr(0, 1), 7, mk_addr(30, 1), 1, gr, gw);
    run_granted(gr, gw, 0, 7, 30, 1, 0, 0);
    request(1, 1, mk_addr(0, 1), 7, mk_addr(30, 1), 1, gr, gw);
    run_granted(gr, gw, 0, 7, 30, 1, 0, 0);

    repeat (3) begin
      tick_sample();
      tick_drive();
    end
    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, compared %0d, mismatched %0d", n_cmp, n_bad);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_port_sched.md
MEM_PORT_SCHED -- requirements
Module: mem_port_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, requester byte-address width.
REQ-003 SHALL have parameter RAM_AW, default 16, RAM word-address width; word index = addr[RAM_AW+1:2].
REQ-004 ACLK  in  1  sole clock; all logic on rising edge.
REQ-005 ARESET  in  1  synchronous, active-high reset.
REQ-006 rd_req / rd_addr / rd_len  in  1 / ADDR_WIDTH / 8  read-burst request, start address, beats-1.
REQ-007 rd_gnt  out  1  one-cycle pulse; requester drops rd_req and captures nothing further.
REQ-008 rd_data / rd_valid / rd_last  out  DATA_WIDTH / 1 / 1  read beat stream; rd_ready  in  1  consumer accept.
REQ-009 wr_req / wr_addr / wr_len  in  1 / ADDR_WIDTH / 8  write-burst request; wr_gnt  out  1  one-cycle pulse.
REQ-010 wr_data / wr_valid / wr_last  in  DATA_WIDTH / 1 / 1  write beats; wr_ready  out  1.
REQ-011 bd_en / bd_addr / bd_data  in  1 / ADDR_WIDTH / DATA_WIDTH  backdoor single-word write, no handshake.
REQ-012 ram_we / ram_waddr / ram_wdata  out  1 / RAM_AW / DATA_WIDTH  RAM write port.
REQ-013 ram_re / ram_raddr  out  1 / RAM_AW; ram_rdata  in  DATA_WIDTH, valid the cycle after ram_re.
REQ-014 busy  out  1  state != IDLE; err_wlast  out  1  sticky wr_last mismatch flag.

Function
REQ-015 SHALL serialise RAM access: at most one of ram_we, ram_re high per cycle.
REQ-016 SHALL implement FSM IDLE, RD_BURST, WR_BURST.
REQ-017 IDLE: one request -> grant it; both -> grant the type not granted last (round-robin); grant pulse and state change in same cycle; addr/len latched.
REQ-018 Burst type INCR only; word index +1 per beat, wraps modulo 2^RAM_AW.
REQ-019 bd_en SHALL win every cycle: ram_we=1 with bd address/data; burst issue stalls that cycle; wr_ready=0 that cycle; bd_en never dropped, any state.
REQ-020 RD_BURST: ram_re issued at cycle t iff beats_to_issue>0, !bd_en, (fifo_count + in_flight - pop_t) < 2.
REQ-021 Read data captured into 2-entry output FIFO at end of t+1; rd_valid from t+2; rd_data/rd_last stable while rd_valid && !rd_ready.
REQ-022 rd_last SHALL be high on beat rd_len+1 only; rd_ready held high, no bd_en -> 1 beat/cycle sustained.
REQ-023 RD_BURST -> IDLE in cycle after rd_valid && rd_ready && rd_last.
REQ-024 WR_BURST: wr_ready = !bd_en; each wr_valid && wr_ready -> ram_we same cycle, current index, wr_data.
REQ-025 Write burst ends on beat count rd/wr_len+1 regardless of wr_last; -> IDLE next cycle.
REQ-026 wr_last high on non-final beat, or low on final beat -> err_wlast set, sticky.
REQ-027 Return to IDLE costs one cycle; next grant earliest in that IDLE cycle.
REQ-028 Backdoor write and later-issued read to same word -> read returns backdoor data.

Reset
REQ-029 ARESET high at edge -> state IDLE, FIFO/in-flight flushed, counters 0, last-granted = write (read wins first tie).
REQ-030 All outputs 0 during/after reset: rd_gnt, wr_gnt, rd_valid, rd_last, wr_ready, ram_we, ram_re, busy, err_wlast; data/address outputs 0.
REQ-031 Reset mid-burst SHALL abandon the burst; requesters re-request; no RAM access in reset cycle even if bd_en=1.

Verification
REQ-032 Preload word 0x10 via bd=0xDEADBEEF; read addr 0x40 len 0, rd_ready=1 -> rd_gnt one cycle, ram_re next, rd_valid 2 cycles after ram_re, rd_data 0xDEADBEEF, rd_last=1.
REQ-033 rd_req and wr_req same cycle from reset -> rd_gnt first; both re-requested after -> wr_gnt; alternation continues.
REQ-034 Write addr 0x0 len 3 data 1..4 then read same, rd_ready toggling 1/0 -> read beats 1,2,3,4 in order, none lost or duplicated, rd_last on 4th.
REQ-035 bd_en every other cycle during 8-beat write -> wr_ready low exactly in bd cycles, 8 writes + bd writes land, no two RAM ops same cycle.
REQ-036 Write len 1 with wr_last on beat 1 -> err_wlast=1 held; ARESET mid 4-beat read -> rd_valid 0 next cycle, busy 0, err_wlast 0.
